wb_ram_responder: RTL

//  Synthesizable Wishbone classic slave backed by a word-addressed RAM with byte

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_ram_bank.sv | 50 +++++
 rtl/wb_ram_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_pkg
// Brief  : Shared Wishbone bus widths and responder FSM state encoding.
// Rev    : 1.0
// ============================================================================
package wb_pkg;

  localparam int WB_ADR_W  = 30;
  localparam int WB_DAT_W  = 32;
  localparam int WB_SEL_W  = 4;
  localparam int WB_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_ram_bank.sv
`default_nettype none
// ============================================================================
// Module : wb_ram_bank
// Brief  : 32-bit synchronous single-port RAM, byte-lane writes, registered
//          read data that returns to zero when no read is issued.
// Rev    : 1.0
// ============================================================================
module wb_ram_bank
  import wb_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [WB_SEL_W-1:0] sel_i,
  input  logic [WB_DAT_W-1:0] wdata_i,
  output logic [WB_DAT_W-1:0] rdata_o
);

  logic [WB_DAT_W-1:0] mem_q [2**ADDR_W];
  logic [WB_DAT_W-1:0] rdata_q;

  // Contents are deliberately never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (sel_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/wb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module : wb_ram_responder
// Brief  : Wishbone classic slave on a byte-lane RAM with programmable wait
//          states. Optional macro WB_RAM_ERR_EN turns out-of-range addresses
//          into err_o responses instead of aliasing.
// Rev    : 1.0
// ============================================================================
module wb_ram_responder
  import wb_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID          = 32'h0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [WB_ADR_W-1:0] wishbone_adr_i,
  input  logic [WB_DAT_W-1:0] wishbone_dat_i,
  output logic [WB_DAT_W-1:0] wishbone_dat_o,
  input  logic [WB_SEL_W-1:0] wishbone_sel_i,
  input  logic                wishbone_we_i,
  input  logic                wishbone_cyc_i,
  input  logic                wishbone_stb_i,
  output logic                wishbone_ack_o,
  output logic                wishbone_err_o
);

  localparam logic [WB_WAIT_W-1:0] WS_INIT = WAIT_STATES[WB_WAIT_W-1:0];
  localparam bit                   NO_WAIT = (WAIT_STATES == 0);

  wb_resp_state_t        state_q;
  logic [WB_WAIT_W-1:0]  cnt_q;
  logic [DEPTH_LOG2-1:0] adr_q;
  logic [WB_DAT_W-1:0]   dat_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic                  we_q;
  logic                  oor_q;
  logic                  ack_q;
  logic                  err_q;

  logic                  req_d;
  logic                  oor_d;
  logic                  go_ack_d;
  logic [DEPTH_LOG2-1:0] cur_adr_d;
  logic [WB_DAT_W-1:0]   cur_dat_d;
  logic [WB_SEL_W-1:0]   cur_sel_d;
  logic                  cur_we_d;
  logic                  cur_oor_d;
  logic                  ram_we_d;
  logic                  ram_re_d;
  logic                  unused_w;

  assign req_d = wishbone_cyc_i & wishbone_stb_i;

`ifdef WB_RAM_ERR_EN
  assign oor_d = |(wishbone_adr_i >> DEPTH_LOG2);
`else
  assign oor_d = 1'b0;
`endif

  // Zero-wait accesses reach ACK straight from IDLE, so the RAM must be fed
  // from the live bus rather than from the request latches.
  always_comb begin
    cur_adr_d = adr_q;
    cur_dat_d = dat_q;
    cur_sel_d = sel_q;
    cur_we_d  = we_q;
    cur_oor_d = oor_q;
    go_ack_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cur_adr_d = wishbone_adr_i[DEPTH_LOG2-1:0];
        cur_dat_d = wishbone_dat_i;
        cur_sel_d = wishbone_sel_i;
        cur_we_d  = wishbone_we_i;
        cur_oor_d = oor_d;
        go_ack_d  = req_d && NO_WAIT;
      end
      WAIT:    go_ack_d = wishbone_cyc_i && (cnt_q == WB_WAIT_W'(1));
      default: go_ack_d = 1'b0;
    endcase
    if (sys_rst) begin
      go_ack_d = 1'b0;
    end
  end

  assign ram_we_d = go_ack_d &  cur_we_d & ~cur_oor_d;
  assign ram_re_d = go_ack_d & ~cur_we_d & ~cur_oor_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (go_ack_d) begin
        ack_q <= ~cur_oor_d;
        err_q <=  cur_oor_d;
      end
      case (state_q)
        IDLE: begin
          if (req_d) begin
            adr_q   <= wishbone_adr_i[DEPTH_LOG2-1:0];
            dat_q   <= wishbone_dat_i;
            sel_q   <= wishbone_sel_i;
            we_q    <= wishbone_we_i;
            oor_q   <= oor_d;
            cnt_q   <= WS_INIT;
            state_q <= NO_WAIT ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!wishbone_cyc_i) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - WB_WAIT_W'(1);
            if (cnt_q == WB_WAIT_W'(1)) begin
              state_q <= ACK;
            end
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  wb_ram_bank #(
    .ADDR_W (DEPTH_LOG2)
  ) u_bank (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .we_i    (ram_we_d),
    .re_i    (ram_re_d),
    .addr_i  (cur_adr_d),
    .sel_i   (cur_sel_d),
    .wdata_i (cur_dat_d),
    .rdata_o (wishbone_dat_o)
  );

  assign wishbone_ack_o = ack_q;
  assign wishbone_err_o = err_q;

  // Upper address bits are ignored when aliasing; ID is informational only.
  assign unused_w = ^{wishbone_adr_i, ID};

endmodule
`default_nettype wire
